// File: rtl/pipe_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_if
//
// Bundle between the 5-stage pipeline datapath and its hazard controller.
//
//   Pipeline -> controller (register numbers and stage qualifiers):
//     id_rs, id_rt, id_use_rs, id_use_rt    sources read by the ID instruction
//     ex_rs, ex_rt                          sources of the EX instruction
//     ex_aw, ex_we, ex_load                 EX destination / write / is-load
//     mem_aw, mem_we, mem_load              MEM destination / write / is-load
//     wb_aw, wb_we                          WB destination / write
//     ex_redirect                           branch/jump resolved in EX
//     ex_halt                               halting syscall in EX
//   Controller -> pipeline:
//     pause_if                              hold PC and IF/ID
//     flush_id, flush_ex                    bubble into IF/ID, ID/EX
//     fwd_a, fwd_b                          EX operand bypass selects
//
// Modports: master = pipeline side, slave = hazard controller.
// -----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic [4:0] ex_rs;
    logic [4:0] ex_rt;
    logic [4:0] ex_aw;
    logic       ex_we;
    logic       ex_load;
    logic [4:0] mem_aw;
    logic       mem_we;
    logic       mem_load;
    logic [4:0] wb_aw;
    logic       wb_we;
    logic       ex_redirect;
    logic       ex_halt;
    logic       pause_if;
    logic       flush_id;
    logic       flush_ex;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt,
        output ex_rs, ex_rt, ex_aw, ex_we, ex_load,
        output mem_aw, mem_we, mem_load, wb_aw, wb_we,
        output ex_redirect, ex_halt,
        input  pause_if, flush_id, flush_ex, fwd_a, fwd_b
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt,
        input  ex_rs, ex_rt, ex_aw, ex_we, ex_load,
        input  mem_aw, mem_we, mem_load, wb_aw, wb_we,
        input  ex_redirect, ex_halt,
        output pause_if, flush_id, flush_ex, fwd_a, fwd_b
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard and sequencing controller for a 5-stage MIPS pipeline. Raises the
// IF pause and the IF/ID, ID/EX bubbles, picks the EX operand bypass source,
// resolves load-use and redirect hazards, and drains the pipeline on a
// halting syscall. Keeps saturating stall/flush event counters.
//
// Parameters:
//   CNT_W         width of stall_cnt / flush_cnt
//   DRAIN_CYCLES  cycles spent draining after a halt is seen in EX
//
// Ports:
//   clk, rst_n    pipeline clock, asynchronous active-low reset
//   hz            pipe_hazard_ctrl_if.slave (stage info in, controls out)
//   halted        pipeline drained (registered); gates the core clock
//   stall_cnt     effective stall cycles in RUN, saturating
//   flush_cnt     effective redirects in RUN, saturating
//
// Build option: define PIPE_HAZARD_FORWARD_EN to enable the operand bypass.
// Without it fwd_a/fwd_b are 00 and the ID instruction stalls while any
// source it reads is still pending in EX, MEM or WB.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int CNT_W        = 16,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_hazard_ctrl_if.slave hz,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);
    localparam int             DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0]  DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);
    localparam logic [DW-1:0]  DRAIN_ONE  = DW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    state_t        state;
    logic [DW-1:0] drain_cnt;

    // Register 0 is hardwired to zero, so it never creates a dependency.
    function automatic logic reg_hit(logic [4:0] src, logic [4:0] aw, logic we);
        return (src != 5'd0) && we && (src == aw);
    endfunction

    logic       rs_ex;
    logic       rt_ex;
    logic       raw_stall;
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;

    assign rs_ex = hz.id_use_rs && reg_hit(hz.id_rs, hz.ex_aw, hz.ex_we);
    assign rt_ex = hz.id_use_rt && reg_hit(hz.id_rt, hz.ex_aw, hz.ex_we);

`ifdef PIPE_HAZARD_FORWARD_EN
    // MEM is younger than WB, so its value is the current one.
    function automatic logic [1:0] bypass_sel(
        logic [4:0] src,
        logic [4:0] m_aw, logic m_we, logic m_load,
        logic [4:0] w_aw, logic w_we
    );
        if (reg_hit(src, m_aw, m_we))
            return m_load ? 2'b11 : 2'b01;
        else if (reg_hit(src, w_aw, w_we))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    // Only a load in EX cannot be bypassed in time: its data exists in MEM.
    assign raw_stall = hz.ex_load && (rs_ex || rt_ex);
    assign fwd_a_sel = bypass_sel(hz.ex_rs, hz.mem_aw, hz.mem_we, hz.mem_load,
                                  hz.wb_aw, hz.wb_we);
    assign fwd_b_sel = bypass_sel(hz.ex_rt, hz.mem_aw, hz.mem_we, hz.mem_load,
                                  hz.wb_aw, hz.wb_we);
`else
    // No bypass: wait until every producer has written the register file.
    logic rs_late;
    logic rt_late;
    logic unused_fwd_inputs;

    assign rs_late = hz.id_use_rs && (reg_hit(hz.id_rs, hz.mem_aw, hz.mem_we) ||
                                      reg_hit(hz.id_rs, hz.wb_aw, hz.wb_we));
    assign rt_late = hz.id_use_rt && (reg_hit(hz.id_rt, hz.mem_aw, hz.mem_we) ||
                                      reg_hit(hz.id_rt, hz.wb_aw, hz.wb_we));
    assign raw_stall = rs_ex || rt_ex || rs_late || rt_late;
    assign fwd_a_sel = 2'b00;
    assign fwd_b_sel = 2'b00;
    assign unused_fwd_inputs = ^{hz.ex_rs, hz.ex_rt, hz.ex_load, hz.mem_load};
`endif

    // Priority: reset > halt/drain > redirect > stall.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        hz.pause_if = 1'b0;
        hz.flush_id = 1'b0;
        hz.flush_ex = 1'b0;
        hz.fwd_a    = fwd_a_sel;
        hz.fwd_b    = fwd_b_sel;
        if (!rst_n) begin
            hz.flush_id = 1'b1;
            hz.flush_ex = 1'b1;
            hz.fwd_a    = 2'b00;
            hz.fwd_b    = 2'b00;
        end else if (state != ST_RUN || hz.ex_halt) begin
            hz.pause_if = 1'b1;
            hz.flush_id = 1'b1;
            hz.flush_ex = 1'b1;
        end else if (hz.ex_redirect) begin
            hz.flush_id = 1'b1;
            hz.flush_ex = 1'b1;
        end else if (raw_stall) begin
            hz.pause_if = 1'b1;
            hz.flush_ex = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
            halted    <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (hz.ex_halt) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= DRAIN_LOAD;
                    end else if (hz.ex_redirect) begin
                        if (flush_cnt != CNT_MAX)
                            flush_cnt <= flush_cnt + CNT_ONE;
                    end else if (raw_stall) begin
                        if (stall_cnt != CNT_MAX)
                            stall_cnt <= stall_cnt + CNT_ONE;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0) begin
                        state  <= ST_HALTED;
                        halted <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - DRAIN_ONE;
                    end
                end
                ST_HALTED: begin
                    halted <= 1'b1;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Self-checking bench for pipe_hazard_ctrl (CNT_W=4 so saturation is reachable).
// Expected values come from a behavioural model of the hazard rules: which
// sources the ID instruction still needs, which stage holds the newest copy
// of an EX operand, and how many edges have passed since a halt was taken.
// Inputs change on the falling edge; outputs are compared 1 time unit later.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;
    localparam int CNT_W = 4;
    localparam int DRAIN = 3;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if bus ();
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .DRAIN_CYCLES(DRAIN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hz        (bus),
        .halted    (halted),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Model state: event totals and edges since the halt was accepted (-1: none).
    int m_stall;
    int m_flush;
    int m_halt_age;

    // ---------------- reference model ----------------
    function automatic bit needs_wait(logic [4:0] src, bit used);
        if (!used || src == 5'd0) return 1'b0;
`ifdef PIPE_HAZARD_FORWARD_EN
        // Bypassable from MEM/WB; only load data still in EX is too late.
        return bus.ex_we && bus.ex_load && src == bus.ex_aw;
`else
        return (bus.ex_we && src == bus.ex_aw) || (bus.mem_we && src == bus.mem_aw) ||
               (bus.wb_we && src == bus.wb_aw);
`endif
    endfunction

    function automatic bit stall_expect();
        return needs_wait(bus.id_rs, bus.id_use_rs) || needs_wait(bus.id_rt, bus.id_use_rt);
    endfunction

`ifdef PIPE_HAZARD_FORWARD_EN
    function automatic logic [1:0] newest_copy(logic [4:0] src);
        if (src == 5'd0) return 2'b00;
        if (bus.mem_we && bus.mem_aw == src) return bus.mem_load ? 2'b11 : 2'b01;
        if (bus.wb_we && bus.wb_aw == src) return 2'b10;
        return 2'b00;
    endfunction
    function automatic logic [3:0] fwd_expect();
        return {newest_copy(bus.ex_rs), newest_copy(bus.ex_rt)};
    endfunction
`else
    function automatic logic [3:0] fwd_expect();
        return 4'b0000;
    endfunction
`endif

    // {pause_if, flush_id, flush_ex, fwd_a, fwd_b}
    function automatic logic [6:0] ctrl_expect();
        logic [2:0] c;
        if (!rst_n) return 7'b0110000;
        if (m_halt_age >= 0 || bus.ex_halt) c = 3'b111;
        else if (bus.ex_redirect)           c = 3'b011;
        else if (stall_expect())            c = 3'b101;
        else                                c = 3'b000;
        return {c, fwd_expect()};
    endfunction

    function automatic logic [6:0] ctrl_now();
        return {bus.pause_if, bus.flush_id, bus.flush_ex, bus.fwd_a, bus.fwd_b};
    endfunction

    // {halted, stall_cnt, flush_cnt}
    function automatic logic [2*CNT_W:0] regs_expect();
        return {m_halt_age >= DRAIN, CNT_W'(m_stall), CNT_W'(m_flush)};
    endfunction

    function automatic logic [2*CNT_W:0] regs_now();
        return {halted, stall_cnt, flush_cnt};
    endfunction

    task automatic model_reset();
        m_stall    = 0;
        m_flush    = 0;
        m_halt_age = -1;
    endtask

    task automatic model_edge();
        if (m_halt_age >= 0) begin
            if (m_halt_age < 1000) m_halt_age++;
        end else if (bus.ex_halt) m_halt_age = 0;
        else if (bus.ex_redirect) m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
        else if (stall_expect())  m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        {bus.id_rs, bus.id_rt, bus.id_use_rs, bus.id_use_rt} = '0;
        {bus.ex_rs, bus.ex_rt, bus.ex_aw, bus.ex_we, bus.ex_load} = '0;
        {bus.mem_aw, bus.mem_we, bus.mem_load, bus.wb_aw, bus.wb_we} = '0;
        bus.ex_redirect = 1'b0;
        bus.ex_halt     = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        idle_inputs();
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        idle_inputs();
        // Inputs that would otherwise redirect and bypass.
        bus.ex_redirect = 1'b1;
        bus.ex_rs = 5'd7; bus.mem_aw = 5'd7; bus.mem_we = 1'b1;
        #1;
        checks++;
        if (ctrl_now() !== 7'b0110000) begin
            errors++; $display("FAIL reset_ctrl got=%b exp=%b", ctrl_now(), 7'b0110000);
        end
        checks++;
        if (regs_now() !== '0) begin
            errors++; $display("FAIL reset_regs got=%h exp=0", regs_now());
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        tick();
    endtask

    task automatic test_bypass();
        logic [1:0] e_mem_alu, e_wb, e_mem_ld;
`ifdef PIPE_HAZARD_FORWARD_EN
        e_mem_alu = 2'b01; e_wb = 2'b10; e_mem_ld = 2'b11;
`else
        e_mem_alu = 2'b00; e_wb = 2'b00; e_mem_ld = 2'b00;
`endif
        idle_inputs();
        bus.ex_rs = 5'd5; bus.mem_aw = 5'd5; bus.mem_we = 1'b1; bus.mem_load = 1'b0;
        bus.wb_aw = 5'd5; bus.wb_we = 1'b1;
        #1;
        checks++;
        if (bus.fwd_a !== e_mem_alu) begin
            errors++; $display("FAIL bypass_mem_over_wb got=%b exp=%b", bus.fwd_a, e_mem_alu);
        end
        bus.mem_load = 1'b1;
        #1;
        checks++;
        if (bus.fwd_a !== e_mem_ld) begin
            errors++; $display("FAIL bypass_mem_load got=%b exp=%b", bus.fwd_a, e_mem_ld);
        end
        bus.mem_load = 1'b0; bus.mem_aw = 5'd6;
        #1;
        checks++;
        if (bus.fwd_a !== e_wb) begin
            errors++; $display("FAIL bypass_wb_only got=%b exp=%b", bus.fwd_a, e_wb);
        end
        bus.ex_rs = 5'd0; bus.mem_aw = 5'd0; bus.wb_aw = 5'd0;
        #1;
        checks++;
        if (bus.fwd_a !== 2'b00) begin
            errors++; $display("FAIL bypass_r0 got=%b exp=00", bus.fwd_a);
        end
        // Same rules on operand b, with write enable off at MEM.
        bus.ex_rt = 5'd9; bus.mem_aw = 5'd9; bus.mem_we = 1'b0; bus.wb_aw = 5'd9;
        #1;
        checks++;
        if (bus.fwd_b !== e_wb || ctrl_now() !== ctrl_expect()) begin
            errors++; $display("FAIL bypass_b got=%b exp=%b", ctrl_now(), ctrl_expect());
        end
        tick();
    endtask

    task automatic test_load_use();
        int s0;
        do_reset();
        s0 = m_stall;
        // lw $2 in EX, add $3,$2,$4 in ID.
        idle_inputs();
        bus.ex_aw = 5'd2; bus.ex_we = 1'b1; bus.ex_load = 1'b1;
        bus.id_rs = 5'd2; bus.id_use_rs = 1'b1; bus.id_rt = 5'd4; bus.id_use_rt = 1'b1;
        #1;
        checks++;
        if (ctrl_now() !== {3'b101, 4'b0000} || ctrl_now() !== ctrl_expect()) begin
            errors++; $display("FAIL load_use_stall got=%b exp=%b", ctrl_now(), ctrl_expect());
        end
        tick();
`ifdef PIPE_HAZARD_FORWARD_EN
        // One bubble later: lw in MEM, add in EX.
        idle_inputs();
        bus.mem_aw = 5'd2; bus.mem_we = 1'b1; bus.mem_load = 1'b1;
        bus.ex_rs = 5'd2; bus.ex_rt = 5'd4; bus.ex_aw = 5'd3; bus.ex_we = 1'b1;
        #1;
        checks++;
        if (ctrl_now() !== 7'b0001100 || ctrl_now() !== ctrl_expect()) begin
            errors++; $display("FAIL load_use_fwd got=%b exp=%b", ctrl_now(), 7'b0001100);
        end
        tick();
        checks++;
        if (int'(stall_cnt) !== s0 + 1) begin
            errors++; $display("FAIL load_use_count got=%0d exp=%0d", stall_cnt, s0 + 1);
        end
`else
        // The add waits in ID while the lw walks through MEM and WB.
        for (int k = 0; k < 2; k++) begin
            bus.ex_aw = 5'd0; bus.ex_we = 1'b0; bus.ex_load = 1'b0;
            bus.mem_aw = (k == 0) ? 5'd2 : 5'd0; bus.mem_we = (k == 0);
            bus.wb_aw  = (k == 1) ? 5'd2 : 5'd0; bus.wb_we  = (k == 1);
            #1;
            checks++;
            if (ctrl_now() !== 7'b1010000) begin
                errors++; $display("FAIL no_fwd_stall k=%0d got=%b exp=1010000", k, ctrl_now());
            end
            tick();
        end
        idle_inputs();
        checks++;
        if (int'(stall_cnt) !== s0 + 3) begin
            errors++; $display("FAIL no_fwd_count got=%0d exp=%0d", stall_cnt, s0 + 3);
        end
`endif
        idle_inputs();
    endtask

    task automatic test_redirect_stall();
        int s0, f0;
        s0 = m_stall; f0 = m_flush;
        idle_inputs();
        bus.ex_aw = 5'd8; bus.ex_we = 1'b1; bus.ex_load = 1'b1;
        bus.id_rt = 5'd8; bus.id_use_rt = 1'b1;
        bus.ex_redirect = 1'b1;
        #1;
        checks++;
        if (ctrl_now() !== 7'b0110000) begin
            errors++; $display("FAIL redirect_stall_ctrl got=%b exp=0110000", ctrl_now());
        end
        tick();
        checks++;
        if (int'(flush_cnt) !== f0 + 1 || int'(stall_cnt) !== s0) begin
            errors++; $display("FAIL redirect_stall_cnt got=%0d/%0d exp=%0d/%0d",
                               flush_cnt, stall_cnt, f0 + 1, s0);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if (n % 60 == 59) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                checks++;
                if (ctrl_now() !== ctrl_expect() || regs_now() !== regs_expect()) begin
                    errors++; $display("FAIL random_reset n=%0d got=%b/%h exp=%b/%h",
                                       n, ctrl_now(), regs_now(), ctrl_expect(), regs_expect());
                end
                @(negedge clk);
                rst_n = 1'b1;
            end
            bus.id_rs = 5'($urandom_range(0, 3)); bus.id_rt = 5'($urandom_range(0, 3));
            bus.id_use_rs = 1'($urandom); bus.id_use_rt = 1'($urandom);
            bus.ex_rs = 5'($urandom_range(0, 3)); bus.ex_rt = 5'($urandom_range(0, 3));
            bus.ex_aw = 5'($urandom_range(0, 3)); bus.ex_we = 1'($urandom);
            bus.ex_load = 1'($urandom);
            bus.mem_aw = 5'($urandom_range(0, 3)); bus.mem_we = 1'($urandom);
            bus.mem_load = 1'($urandom);
            bus.wb_aw = 5'($urandom_range(0, 3)); bus.wb_we = 1'($urandom);
            bus.ex_redirect = ($urandom_range(0, 7) == 0);
            bus.ex_halt = 1'b0;
            #1;
            checks++;
            if (ctrl_now() !== ctrl_expect()) begin
                errors++; $display("FAIL random_ctrl n=%0d got=%b exp=%b", n, ctrl_now(), ctrl_expect());
            end
            tick();
            checks++;
            if (regs_now() !== regs_expect()) begin
                errors++; $display("FAIL random_regs n=%0d got=%h exp=%h", n, regs_now(), regs_expect());
            end
        end
        idle_inputs();
    endtask

    task automatic test_saturation();
        do_reset();
        idle_inputs();
        bus.ex_aw = 5'd3; bus.ex_we = 1'b1; bus.ex_load = 1'b1;
        bus.id_rs = 5'd3; bus.id_use_rs = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (int'(stall_cnt) !== ((i + 1 < CMAX) ? i + 1 : CMAX)) begin
                errors++; $display("FAIL saturation i=%0d got=%0d exp=%0d", i, stall_cnt,
                                   (i + 1 < CMAX) ? i + 1 : CMAX);
            end
        end
        checks++;
        if (stall_cnt !== 4'd15 || regs_now() !== regs_expect()) begin
            errors++; $display("FAIL saturation_hold got=%0d exp=15", stall_cnt);
        end
        idle_inputs();
    endtask

    task automatic test_halt();
        int f0;
        do_reset();
        idle_inputs();
        for (int c = 0; c < 10; c++) tick();
        f0 = m_flush;
        bus.ex_halt = 1'b1;
        for (int e = 0; e < 8; e++) begin
            // e = number of edges since the halt was presented.
            #1;
            checks++;
            if (ctrl_now() !== 7'b1110000 || ctrl_now() !== ctrl_expect()) begin
                errors++; $display("FAIL halt_ctrl e=%0d got=%b exp=1110000", e, ctrl_now());
            end
            checks++;
            if (halted !== (e > DRAIN) || regs_now() !== regs_expect()) begin
                errors++; $display("FAIL halt_flag e=%0d got=%b exp=%b", e, halted, e > DRAIN);
            end
            tick();
            bus.ex_halt = 1'b0;
            bus.ex_redirect = (e == 0);
        end
        checks++;
        if (int'(flush_cnt) !== f0 || halted !== 1'b1) begin
            errors++; $display("FAIL halt_redirect_ignored got=%0d/%b exp=%0d/1", flush_cnt, halted, f0);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        idle_inputs();
        bus.ex_redirect = 1'b1;
        tick();
        bus.ex_redirect = 1'b0;
        bus.ex_halt = 1'b1;
        tick();
        bus.ex_halt = 1'b0;
        tick();
        // Mid-cycle asynchronous reset while draining, with bypass inputs live.
        bus.ex_rs = 5'd4; bus.mem_aw = 5'd4; bus.mem_we = 1'b1;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (regs_now() !== '0 || ctrl_now() !== 7'b0110000) begin
            errors++; $display("FAIL mid_drain_reset got=%h/%b exp=0/0110000", regs_now(), ctrl_now());
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        bus.ex_redirect = 1'b1;
        #1;
        checks++;
        if (ctrl_now() !== 7'b0110000 || bus.pause_if !== 1'b0) begin
            errors++; $display("FAIL mid_drain_run got=%b exp=0110000", ctrl_now());
        end
        tick();
        checks++;
        if (flush_cnt !== 4'd1 || halted !== 1'b0 || regs_now() !== regs_expect()) begin
            errors++; $display("FAIL mid_drain_resume got=%h exp=%h", regs_now(), regs_expect());
        end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_bypass();
        test_load_use();
        test_redirect_stall();
        test_random();
        test_saturation();
        test_halt();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and sequencing controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB). It drives the pipeline-register bubbles and the IF pause, and selects the EX-stage operand bypass sources. It resolves load-use and redirect (branch/jump) hazards and drains the pipeline on a halting syscall. It also keeps saturating stall and flush event counters for performance inspection.

## Interface
- CNT_W, 16, width of the stall/flush event counters
- DRAIN_CYCLES, 3, cycles spent draining after a halt is detected in EX

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous, active-low reset
- id_rs, id_rt  in  5 each  source register numbers of the instruction in ID
- id_use_rs, id_use_rt  in  1 each  instruction in ID actually reads rs / rt
- ex_rs, ex_rt  in  5 each  source register numbers of the instruction in EX
- ex_aw, ex_we, ex_load  in  5/1/1  EX destination, write enable, is-load
- mem_aw, mem_we, mem_load  in  5/1/1  same for MEM
- wb_aw, wb_we  in  5/1  same for WB
- ex_redirect  in  1  branch taken, jump or jump-register resolved in EX
- ex_halt  in  1  halting syscall in EX
- pause_if  out  1  hold PC and the IF/ID register
- flush_id  out  1  load a bubble into IF/ID (drives rst_ID)
- flush_ex  out  1  load a bubble into ID/EX (drives rst_EX)
- fwd_a, fwd_b  out  2 each  EX operand source: 00 regfile, 01 MEM ALU result, 11 MEM load data, 10 WB write data
- halted  out  1  pipeline drained; gates the core clock
- stall_cnt, flush_cnt  out  CNT_W each  event counters

## Operation
- A register match requires a nonzero address, an asserted write enable and equal numbers. Register 0 never matches.
- Load-use stall: ex_load && ex_we && the EX destination matches a used ID source.
  - Response: pause_if=1, flush_ex=1, flush_id=0.
- Redirect: ex_redirect=1 gives flush_id=1, flush_ex=1, pause_if=0.
- Priority is halt > redirect > stall.
  - When a redirect coincides with a load-use stall, only the redirect acts and the stall is not counted.
- Forwarding (fwd_a for ex_rs, fwd_b for ex_rt):
  - A MEM match wins over a WB match.
  - A MEM match gives 11 if mem_load, otherwise 01.
  - A WB-only match gives 10.
  - No match gives 00.
- FSM states and transitions:
  - RUN → DRAIN when ex_halt=1. A drain counter is loaded with DRAIN_CYCLES-1.
  - DRAIN decrements the counter each cycle and moves to HALTED when the counter is 0.
  - HALTED is held until reset.
- In DRAIN and HALTED: pause_if=1, flush_id=1, flush_ex=1, and ex_redirect is ignored. MEM/WB are not flushed, so older instructions retire.
- The halt output is registered: halted=1 only in HALTED.
- Counters:
  - stall_cnt increments on every RUN cycle with an effective load-use stall.
  - flush_cnt increments on every RUN cycle with an effective redirect.
  - Both saturate at all-ones and do not wrap.
  - Neither counts during DRAIN or HALTED.

## Timing
- pause_if, flush_id, flush_ex, fwd_a and fwd_b are combinational from inputs and state, valid in the same cycle. Consumers sample them at the next posedge.
- Load-use latency:
  - The dependent instruction is held exactly one cycle.
  - It enters EX while the load is in MEM, with fwd=11.
- Redirect costs 2 bubbles.
- Halt:
  - ex_halt is seen at edge 0.
  - halted rises after edge DRAIN_CYCLES, i.e. 3 cycles later.
- Reset (rst_n low, asynchronous, also mid-operation):
  - Registered state: state=RUN, drain counter=0, halted=0, stall_cnt=0, flush_cnt=0.
  - While rst_n is low, combinational outputs are forced: flush_id=1, flush_ex=1, pause_if=0, fwd_a=fwd_b=00.
  - Normal operation resumes on the first posedge after deassertion.

## Configuration
- PIPE_HAZARD_FORWARD_EN defined: behaviour is exactly as above.
- PIPE_HAZARD_FORWARD_EN undefined:
  - fwd_a and fwd_b are tied to 00.
  - A stall (pause_if=1, flush_ex=1) is raised while any used ID source matches the EX, MEM or WB destination, regardless of load.
  - Such a stall can last up to 3 cycles, and every stalled cycle increments stall_cnt.

## Test plan
- Load-use: lw $2 in EX, add $3,$2,$4 in ID → one cycle of pause_if=1/flush_ex=1, then add in EX with fwd_a=11; stall_cnt=1.
- Bypass priority: ex_rs=5 with mem_aw=5/mem_we=1/mem_load=0 and wb_aw=5/wb_we=1 → fwd_a=01; change mem_aw to 6 → fwd_a=10; set ex_rs=0 with both destinations 0 → fwd_a=00.
- Redirect during stall: ex_redirect=1 together with a load-use match → flush_id=1, flush_ex=1, pause_if=0; flush_cnt=1, stall_cnt unchanged.
- Halt: pulse ex_halt at cycle 10 → pause_if, flush_id and flush_ex held from cycle 10; halted=1 from cycle 13 onward; a redirect at cycle 11 leaves flush_cnt unchanged.
- Reset mid-drain: assert rst_n=0 at cycle 11 → halted=0, counters=0, flush_id=flush_ex=1 immediately; after release, state RUN.
- Saturation: with CNT_W=4, 20 consecutive load-use stalls → stall_cnt=15 and held.
